// File: rtl/clock_ctrl_if.sv
// Bundle of control, button, digit-status and strobe signals between the
// clock_ctrl sequencer and the digit-counter chain / front panel.
interface clock_ctrl_if;
  logic       ena;
  logic       btn_mode;
  logic       btn_inc;
  logic       max_sl;
  logic       max_sh;
  logic       max_ml;
  logic       max_mh;
  logic       max_hl;
  logic       hour_max;
  logic       ena_sl;
  logic       ena_sh;
  logic       ena_ml;
  logic       ena_mh;
  logic       ena_hl;
  logic       ena_hh;
  logic       clr_s;
  logic       clr_h;
  logic [1:0] mode;
  logic       blink;

  modport master (
    output ena, btn_mode, btn_inc, max_sl, max_sh, max_ml, max_mh, max_hl, hour_max,
    input  ena_sl, ena_sh, ena_ml, ena_mh, ena_hl, ena_hh, clr_s, clr_h, mode, blink
  );

  modport slave (
    input  ena, btn_mode, btn_inc, max_sl, max_sh, max_ml, max_mh, max_hl, hour_max,
    output ena_sl, ena_sh, ena_ml, ena_mh, ena_hl, ena_hh, clr_s, clr_h, mode, blink
  );
endinterface

// File: rtl/clock_ctrl.sv
// HH:MM:SS sequencer: 1 Hz prescaler, digit-enable cascade, hour wrap and set-mode FSM.
// Define AUTO_REPEAT_EN to enable auto-repeat of btn_inc while held in a set mode.
module clock_ctrl #(
  parameter int TICK_DIV = 1000000
`ifdef AUTO_REPEAT_EN
  , parameter int REPEAT_TICKS = 2
`endif
) (
  input  logic        clk,
  input  logic        res,
  clock_ctrl_if.slave bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MIN = 2'd2} mode_e;

  typedef struct packed {
    logic sl, sh, ml, mh, hl, hh;
  } strobe_t;

  logic [PW-1:0] r_psc;
  logic [3:0]    r_mode_sh, r_inc_sh;
  logic          r_mode_pls, r_inc_pls;
  mode_e         r_state, w_state_nx;
  strobe_t       r_stb, w_stb_nx;
  logic          r_clr_s, w_clr_s_nx;
  logic          r_clr_h, w_clr_h_nx;
  logic          r_blink, w_blink_nx;
  logic          w_psc_clr, w_tick, w_rep, w_inc_p;
  logic          w_c_ml, w_c_mh, w_c_h;

  assign w_tick = (r_psc == TICK_LAST) && bus.ena;

  // Bits [1:0] synchronise, bit [2] is the clean level, bit [3] the edge reference.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!res) begin
      r_mode_sh  <= '0;
      r_inc_sh   <= '0;
      r_mode_pls <= 1'b0;
      r_inc_pls  <= 1'b0;
    end else begin
      r_mode_sh  <= {r_mode_sh[2:0], bus.btn_mode};
      r_inc_sh   <= {r_inc_sh[2:0], bus.btn_inc};
      r_mode_pls <= bus.ena & r_mode_sh[2] & ~r_mode_sh[3];
      r_inc_pls  <= bus.ena & r_inc_sh[2] & ~r_inc_sh[3];
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      r_psc <= '0;
    end else if (w_psc_clr || w_tick) begin
      r_psc <= '0;
    end else if (bus.ena) begin
      r_psc <= r_psc + PW'(1);
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 2);
  logic [RW-1:0] r_rep_cnt;
  logic          w_set;

  assign w_set = (r_state != RUN);
  assign w_rep = w_tick & w_set & r_inc_sh[2] & (r_rep_cnt == RW'(REPEAT_TICKS));

  always_ff @(posedge clk) begin
    if (!res) begin
      r_rep_cnt <= '0;
    end else if (bus.ena) begin
      if (!w_set || !r_inc_sh[2] || r_mode_pls) begin
        r_rep_cnt <= '0;
      end else if (w_tick && (r_rep_cnt != RW'(REPEAT_TICKS))) begin
        r_rep_cnt <= r_rep_cnt + RW'(1);
      end
    end
  end
`else
  assign w_rep = 1'b0;
`endif

  // A mode pulse always wins over a coincident increment.
  assign w_inc_p = (r_inc_pls | w_rep) & ~r_mode_pls;
  assign w_c_ml  = bus.max_sl & bus.max_sh;
  assign w_c_mh  = w_c_ml & bus.max_ml;
  assign w_c_h   = w_c_mh & bus.max_mh;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    w_state_nx = r_state;
    w_stb_nx   = '0;
    w_clr_s_nx = 1'b0;
    w_clr_h_nx = 1'b0;
    w_blink_nx = r_blink;
    w_psc_clr  = 1'b0;
    if (bus.ena) begin
      unique case (r_state)
        RUN: begin
          w_blink_nx = 1'b0;
          if (r_mode_pls) begin
            w_state_nx = SET_HR;
            w_clr_s_nx = 1'b1;
          end else if (w_tick) begin
            w_stb_nx.sl = 1'b1;
            w_stb_nx.sh = bus.max_sl;
            w_stb_nx.ml = w_c_ml;
            w_stb_nx.mh = w_c_mh;
            w_stb_nx.hl = w_c_h & ~bus.hour_max;
            w_stb_nx.hh = w_c_h & ~bus.hour_max & bus.max_hl;
            w_clr_h_nx  = w_c_h & bus.hour_max;
          end
        end
        SET_HR: begin
          if (w_tick) w_blink_nx = ~r_blink;
          if (r_mode_pls) begin
            w_state_nx = SET_MIN;
          end else if (w_inc_p) begin
            w_clr_h_nx  = bus.hour_max;
            w_stb_nx.hl = ~bus.hour_max;
            w_stb_nx.hh = ~bus.hour_max & bus.max_hl;
          end
        end
        SET_MIN: begin
          if (w_tick) w_blink_nx = ~r_blink;
          if (r_mode_pls) begin
            w_state_nx = RUN;
            w_blink_nx = 1'b0;
            w_psc_clr  = 1'b1;
          end else if (w_inc_p) begin
            w_stb_nx.ml = 1'b1;
            w_stb_nx.mh = bus.max_ml;
          end
        end
        default: w_state_nx = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      r_state <= RUN;
      r_stb   <= '0;
      r_clr_s <= 1'b0;
      r_clr_h <= 1'b0;
      r_blink <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_stb   <= w_stb_nx;
      r_clr_s <= w_clr_s_nx;
      r_clr_h <= w_clr_h_nx;
      r_blink <= w_blink_nx;
    end
  end

  assign bus.ena_sl = r_stb.sl;
  assign bus.ena_sh = r_stb.sh;
  assign bus.ena_ml = r_stb.ml;
  assign bus.ena_mh = r_stb.mh;
  assign bus.ena_hl = r_stb.hl;
  assign bus.ena_hh = r_stb.hh;
  assign bus.clr_s  = r_clr_s;
  assign bus.clr_h  = r_clr_h;
  assign bus.mode   = r_state;
  assign bus.blink  = r_blink;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl with TICK_DIV=4: cascade, hour wrap, set-mode FSM,
// button latency, ena freeze and synchronous reset.
module tb_clock_ctrl;
  logic clk = 1'b0;
  logic res;
  int   n_checks = 0;
  int   n_fail   = 0;

  clock_ctrl_if bus ();

  clock_ctrl #(.TICK_DIV(4)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // {sl, sh, ml, mh, hl, hh, clr_h, clr_s}
  logic [7:0] w_obs;
  assign w_obs = {bus.ena_sl, bus.ena_sh, bus.ena_ml, bus.ena_mh,
                  bus.ena_hl, bus.ena_hh, bus.clr_h, bus.clr_s};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_max(input logic sl, sh, ml, mh, hl, hm);
    bus.max_sl   = sl;
    bus.max_sh   = sh;
    bus.max_ml   = ml;
    bus.max_mh   = mh;
    bus.max_hl   = hl;
    bus.hour_max = hm;
  endtask

  initial begin
    res          = 1'b0;
    bus.ena      = 1'b1;
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    set_max(0, 0, 0, 0, 0, 0);
    step(2);
    check("rst_strobes", w_obs, 8'h00);
    check("rst_mode", {6'b0, bus.mode}, 8'd0);
    check("rst_blink", {7'b0, bus.blink}, 8'd0);

    @(negedge clk);
    res = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      check("run_sl", {7'b0, bus.ena_sl}, (k % 4 == 0) ? 8'd1 : 8'd0);
      check("run_others", {1'b0, w_obs[6:0]}, 8'h00);
    end

    set_max(1, 1, 1, 1, 1, 0);
    step(4);
    check("casc_full", w_obs, 8'b1111_1100);
    set_max(1, 1, 1, 1, 1, 1);
    step(4);
    check("casc_hour_wrap", w_obs, 8'b1111_0010);
    set_max(1, 1, 0, 1, 1, 1);
    step(4);
    check("casc_partial", w_obs, 8'b1110_0000);
    set_max(0, 0, 0, 0, 0, 0);

    // RUN -> SET_HR: response lands on the fifth edge after the press is first sampled
    bus.btn_mode = 1'b1;
    step(4);
    check("mode_latency_early", {6'b0, bus.mode}, 8'd0);
    step(1);
    check("mode_set_hr", {6'b0, bus.mode}, 8'd1);
    check("clr_s_pulse", w_obs, 8'b0000_0001);
    step(1);
    check("clr_s_single", {7'b0, bus.clr_s}, 8'd0);
    check("blink_entry", {7'b0, bus.blink}, 8'd0);
    bus.btn_mode = 1'b0;
    step(2);
    check("blink_toggle", {7'b0, bus.blink}, 8'd1);
    check("set_no_cascade", {7'b0, bus.ena_sl}, 8'd0);

    set_max(0, 0, 0, 0, 0, 1);
    bus.btn_inc = 1'b1;
    step(4);
    check("hr_inc_early", {7'b0, bus.clr_h}, 8'd0);
    step(1);
    check("hr_inc_wrap", w_obs, 8'b0000_0010);
    step(1);
    check("hr_inc_single", w_obs, 8'h00);
    bus.btn_inc = 1'b0;
    step(4);

    set_max(0, 0, 0, 0, 1, 0);
    bus.btn_inc = 1'b1;
    step(4);
    check("hr_inc2_early", {7'b0, bus.ena_hl}, 8'd0);
    step(1);
    check("hr_inc_carry", w_obs, 8'b0000_1100);
    bus.btn_inc = 1'b0;
    set_max(0, 0, 0, 0, 0, 0);
    step(4);

    bus.btn_mode = 1'b1;
    bus.btn_inc  = 1'b1;
    step(4);
    check("simul_early", {6'b0, bus.mode}, 8'd1);
    step(1);
    check("simul_mode", {6'b0, bus.mode}, 8'd2);
    check("simul_no_strobe", w_obs, 8'h00);
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    step(4);

    set_max(0, 0, 1, 0, 0, 0);
    bus.btn_inc = 1'b1;
    step(4);
    check("min_inc_early", {7'b0, bus.ena_ml}, 8'd0);
    step(1);
    check("min_inc_carry", w_obs, 8'b0011_0000);
    step(1);
    check("min_inc_single", w_obs, 8'h00);
    step(3);
    check("min_inc_no_repeat", w_obs, 8'h00);
    bus.btn_inc = 1'b0;
    set_max(0, 0, 0, 0, 0, 0);
    step(4);

    // SET_MIN -> RUN reloads the prescaler
    bus.btn_mode = 1'b1;
    step(4);
    check("to_run_early", {6'b0, bus.mode}, 8'd2);
    step(1);
    check("to_run_mode", {6'b0, bus.mode}, 8'd0);
    check("to_run_blink", {7'b0, bus.blink}, 8'd0);
    bus.btn_mode = 1'b0;
    step(3);
    check("first_tick_early", {7'b0, bus.ena_sl}, 8'd0);
    step(1);
    check("first_tick", w_obs, 8'b1000_0000);

    step(1);
    bus.ena = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("freeze_strobes", w_obs, 8'h00);
    end
    bus.ena = 1'b1;
    step(2);
    check("resume_early", {7'b0, bus.ena_sl}, 8'd0);
    step(1);
    check("resume_tick", {7'b0, bus.ena_sl}, 8'd1);

    bus.btn_mode = 1'b1;
    step(5);
    check("reach_set_hr", {6'b0, bus.mode}, 8'd1);
    bus.btn_mode = 1'b0;
    step(4);
    bus.btn_mode = 1'b1;
    step(5);
    check("reach_set_min", {6'b0, bus.mode}, 8'd2);
    bus.btn_mode = 1'b0;
    step(2);
    check("set_min_blink", {7'b0, bus.blink}, 8'd1);
    res = 1'b0;
    step(1);
    check("mid_rst_mode", {6'b0, bus.mode}, 8'd0);
    check("mid_rst_blink", {7'b0, bus.blink}, 8'd0);
    check("mid_rst_strobes", w_obs, 8'h00);
    res = 1'b1;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
